datapath_rr_arbiter: RTL
========================

// Module: datapath_rr_arbiter
// PURPOSE
//   Round-robin arbiter/sequencer sharing one registered ALU/mult/shift datapath among NUM_REQ requesters.
//   Accepts one operation at a time via valid/ready, drives the datapath operands and waits the fixed datapath latency.
//   Captures result/address and returns them with the requester ID via a valid/ready response channel.
//   Sits between bus-side requesters and the datapath host core.
// PARAMETERS
//   NUM_REQ     4   number of requesters (2..8)
//   DATA_WIDTH  32  operand/result width
//   ADDR_WIDTH  16  address width
//   DP_LATENCY  1   datapath input-to-output register latency in cycles (>=1)
//   ID_W        $clog2(NUM_REQ)  requester ID width (localparam)
// PORTS
//   clk         in   1                   clock, rising edge
//   rst_n       in   1                   asynchronous active-low reset
//   req_valid   in   NUM_REQ             per-requester operation valid
//   req_ready   out  NUM_REQ             per-requester accept (one-hot or zero)
//   req_a       in   NUM_REQ*DATA_WIDTH  operand A, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_b       in   NUM_REQ*DATA_WIDTH  operand B, same packing
//   req_op      in   NUM_REQ*4           alu_op, same packing
//   req_addr    in   NUM_REQ*ADDR_WIDTH  address, same packing
//   dp_a/dp_b   out  DATA_WIDTH          datapath operands
//   dp_op       out  4                   datapath alu_op
//   dp_addr     out  ADDR_WIDTH          datapath addr_in
//   dp_result   in   DATA_WIDTH          datapath result_out
//   dp_addr_out in   ADDR_WIDTH          datapath addr_out
//   rsp_valid   out  1                   response valid
//   rsp_ready   in   1                   response accept
//   rsp_id      out  ID_W                requester ID of response
//   rsp_data    out  DATA_WIDTH          captured dp_result
//   rsp_addr    out  ADDR_WIDTH          captured dp_addr_out
//   busy        out  1                   high whenever state != IDLE
// BEHAVIOUR
//   - Reset (async, rst_n=0): state=IDLE, rr_ptr=0, all outputs 0 (req_ready, dp_*, rsp_*, busy). In-flight op dropped, no response.
//   - FSM: IDLE -> EXEC -> RESP -> IDLE.
//   - IDLE:
//     - Grant g = first i with req_valid[i], searching from rr_ptr upward, wrapping NUM_REQ-1 -> 0.
//     - req_ready[g]=1 combinationally, all other bits 0. No req_valid means req_ready=0.
//     - Accepting edge: latch a/b/op/addr of g into dp_* regs and g into rsp_id.
//     - Same edge: rr_ptr <= (g==NUM_REQ-1) ? 0 : g+1; cnt <= DP_LATENCY; go to EXEC.
//   - EXEC: dp_* held stable. cnt decrements each edge. At the edge where cnt==0, capture dp_result->rsp_data and dp_addr_out->rsp_addr, set rsp_valid=1, go to RESP.
//   - Latency: rsp_valid rises on the (DP_LATENCY+1)th edge after the accepting edge (2 edges at default).
//   - RESP:
//     - rsp_valid/id/data/addr held stable until rsp_ready=1.
//     - At that edge rsp_valid <= 0 and state goes to IDLE.
//     - rsp_ready low indefinitely stalls the block; no new grants.
//   - req_ready is 0 in EXEC and RESP. One op outstanding max; peak throughput is 1 op per DP_LATENCY+3 cycles.
//   - dp_* keep the last issued values in IDLE/RESP, so the datapath sees no spurious operand changes.
//   - A requester dropping req_valid before grant is legal: not granted, rr_ptr unchanged.
//   - rsp_ready while rsp_valid=0 is ignored.
// CONFIGURATION
//   DP_ARB_PRIO_EN
//     - Defined: requester 0 wins whenever req_valid[0]=1 in IDLE, regardless of rr_ptr.
//       - Such a grant sets rr_ptr to 1.
//       - Other requesters follow round-robin when req_valid[0]=0.
//     - Undefined: pure round-robin for all requesters.
// TESTING
//   1. Reset assert mid-EXEC -> next cycle busy=0, rsp_valid=0, req_ready=0. After release, first grant goes to requester 0.
//   2. Single op req0, a=5, b=3, op=0, DP_LATENCY=1, rsp_ready=1; model datapath as 1-cycle add -> rsp_valid 2 edges after accept, rsp_id=0, rsp_data=8.
//   3. All 4 req_valid held high -> grant order 0,1,2,3,0; exactly one req_ready bit per IDLE cycle.
//   4. rsp_ready=0 for 10 cycles -> rsp_* stable, req_ready=0 throughout. Raising rsp_ready -> IDLE next edge, next grant follows.
//   5. rr_ptr=3 with only req1 valid -> wrap search grants 1, rr_ptr becomes 2.
//   6. DP_ARB_PRIO_EN defined, req0 and req2 valid, rr_ptr=2 -> req0 granted, rr_ptr becomes 1. Undefined -> req2 granted.

Source files
------------

// File: rtl/datapath_rr_arbiter.sv
// Round-robin sequencer that shares one registered datapath among NUM_REQ requesters.
// Define DP_ARB_PRIO_EN to give requester 0 absolute priority over the rotation.
module datapath_rr_arbiter #(
  parameter  int NUM_REQ    = 4,
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 16,
  parameter  int DP_LATENCY = 1,
  localparam int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  input  logic [NUM_REQ*4-1:0]         req_op,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [DATA_WIDTH-1:0]        dp_a,
  output logic [DATA_WIDTH-1:0]        dp_b,
  output logic [3:0]                   dp_op,
  output logic [ADDR_WIDTH-1:0]        dp_addr,
  input  logic [DATA_WIDTH-1:0]        dp_result,
  input  logic [ADDR_WIDTH-1:0]        dp_addr_out,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [ID_W-1:0]              rsp_id,
  output logic [DATA_WIDTH-1:0]        rsp_data,
  output logic [ADDR_WIDTH-1:0]        rsp_addr,
  output logic                         busy
);

  localparam int CNT_W = $clog2(DP_LATENCY + 1);
  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);
  localparam logic [ID_W:0]   NREQ    = (ID_W + 1)'(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

  state_t state_q, state_d;

  logic [ID_W-1:0]        rr_ptr;
  logic [CNT_W-1:0]       cnt;
  logic [2*NUM_REQ-1:0]   dbl;
  logic [NUM_REQ-1:0]     rot;
  logic [NUM_REQ-1:0]     gnt_oh;
  logic [ID_W-1:0]        off;
  logic [ID_W:0]          sum;
  logic [ID_W-1:0]        gnt;
  logic                   found;
  logic                   accept;
  logic [DATA_WIDTH-1:0]  a_sel;
  logic [DATA_WIDTH-1:0]  b_sel;
  logic [3:0]             op_sel;
  logic [ADDR_WIDTH-1:0]  addr_sel;

  // Rotate so rr_ptr sits at bit 0, find the lowest set bit, rotate back.
  always_comb begin : arb
    dbl   = {req_valid, req_valid} >> rr_ptr;
    rot   = dbl[NUM_REQ-1:0];
    found = 1'b0;
    off   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        off   = ID_W'(k);
      end
    end
    sum = {1'b0, rr_ptr} + {1'b0, off};
    if (sum >= NREQ) sum = sum - NREQ;
    gnt = sum[ID_W-1:0];
`ifdef DP_ARB_PRIO_EN
    if (req_valid[0]) gnt = '0;
`endif
  end

  always_comb begin : sel
    gnt_oh   = '0;
    a_sel    = '0;
    b_sel    = '0;
    op_sel   = '0;
    addr_sel = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        gnt_oh[i] = found;
        a_sel     = req_a[i*DATA_WIDTH +: DATA_WIDTH];
        b_sel     = req_b[i*DATA_WIDTH +: DATA_WIDTH];
        op_sel    = req_op[i*4 +: 4];
        addr_sel  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
      end
    end
  end

  assign accept    = (state_q == IDLE) && found;
  assign req_ready = (state_q == IDLE && rst_n) ? gnt_oh : '0;
  assign busy      = (state_q != IDLE);
  assign rsp_valid = (state_q == RESP);

  always_comb begin : fsm
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (found) state_d = EXEC;
      EXEC:    if (cnt == '0) state_d = RESP;
      RESP:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr   <= '0;
      cnt      <= '0;
      dp_a     <= '0;
      dp_b     <= '0;
      dp_op    <= '0;
      dp_addr  <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
      rsp_addr <= '0;
    end else if (accept) begin
      dp_a    <= a_sel;
      dp_b    <= b_sel;
      dp_op   <= op_sel;
      dp_addr <= addr_sel;
      rsp_id  <= gnt;
      rr_ptr  <= (gnt == LAST_ID) ? '0 : gnt + ID_W'(1);
      cnt     <= CNT_W'(DP_LATENCY);
    end else if (state_q == EXEC) begin
      if (cnt == '0) begin
        rsp_data <= dp_result;
        rsp_addr <= dp_addr_out;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule
